branch_resolve_ctrl: RTL and testbench

Sequences the branch predictor across the pipeline. It buffers every decoded branch together with the prediction made for it, then retires entries in order as EXEC resolves them. On each retirement it drives a single training update to the predictor and, on a misprediction, a fetch redirect plus a pipeline flush. It sits between DECODE/EXEC and the predictor's update port, so the predictor never has to guess when EXEC feedback is valid.

---
 rtl/bp_pkg.sv | 19 +
 rtl/branch_queue.sv | 62 ++++++
 rtl/branch_resolve_ctrl.sv | 128 ++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch resolution controller and its queue.
package bp_pkg;

  // Address width of the queued payload; top-level ADDR_W must equal this.
  localparam int unsigned BP_ADDR_W = 32;

  typedef struct packed {
    logic [BP_ADDR_W-1:0] pc;
    logic [BP_ADDR_W-1:0] target;
    logic                 pred_taken;
    logic [BP_ADDR_W-1:0] pred_addr;
  } bq_entry_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } bq_state_t;

endpackage

// File: rtl/branch_queue.sv
// In-order FIFO of in-flight branches with push, pop and whole-queue clear.
module branch_queue
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  bq_entry_t              wdata,
  output bq_entry_t              rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_nxt;
  logic             push_ok;
  logic             pop_ok;
  bq_entry_t        mem [DEPTH];

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full & ~clear;
  assign pop_ok   = pop & ~empty;
  assign head_nxt = pop_ok ? head + PTR_W'(1) : head;
  assign rdata    = mem[head];

  // Pointer and occupancy tracking; clear collapses tail onto the new head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= head_nxt;
      tail  <= head_nxt;
      count <= '0;
    end else begin
      head <= head_nxt;
      if (push_ok) tail <= tail + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; payload needs no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[tail] <= wdata;
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Buffers decoded branches, retires them in order on EXEC resolution and
// drives predictor training, fetch redirect and flush.
module branch_resolve_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ADDR_W      = BP_ADDR_W,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   d_valid,
  input  logic                   d_is_branch,
  input  logic [ADDR_W-1:0]      d_pc,
  input  logic [ADDR_W-1:0]      d_target_addr,
  input  logic                   d_pred_taken,
  input  logic [ADDR_W-1:0]      d_pred_addr,
  output logic                   d_ready,
  input  logic                   x_valid,
  input  logic                   x_taken,
  output logic                   upd_valid,
  output logic [ADDR_W-1:0]      upd_pc,
  output logic                   upd_taken,
  output logic [ADDR_W-1:0]      upd_target,
  output logic                   redirect_valid,
  output logic [ADDR_W-1:0]      redirect_addr,
  output logic                   flush,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   underflow
);

  localparam int unsigned RC_W = $clog2(RECOVER_CYC + 1);

  bq_state_t         state;
  logic [RC_W-1:0]   rcnt;
  bq_entry_t         head_e;
  bq_entry_t         push_e;
  logic              q_full;
  logic              q_empty;
  logic [ADDR_W-1:0] head_pc;
  logic [ADDR_W-1:0] head_target;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] actual_next;
  logic [ADDR_W-1:0] pred_next;
  logic              pop_c;
  logic              push_c;
  logic              mispredict_c;
  logic              underflow_c;

  // Resolve the head branch against its prediction.
  always_comb begin
    head_pc      = head_e.pc;
    head_target  = head_e.target;
    pc_plus4     = head_pc + ADDR_W'(4);
    actual_next  = x_taken ? head_target : pc_plus4;
    pred_next    = head_e.pred_taken ? head_e.pred_addr : pc_plus4;
    pop_c        = x_valid & ~q_empty & (state == RUN);
    underflow_c  = x_valid & q_empty & (state == RUN);
    mispredict_c = pop_c & (actual_next != pred_next);
    push_c       = d_valid & d_is_branch & d_ready & ~mispredict_c;
    push_e       = '{pc:         d_pc,
                     target:     d_target_addr,
                     pred_taken: d_pred_taken,
                     pred_addr:  d_pred_addr};
  end

  assign d_ready = (state == RUN) & ~q_full;

  branch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .clear (mispredict_c),
    .wdata (push_e),
    .rdata (head_e),
    .count (occupancy),
    .full  (q_full),
    .empty (q_empty)
  );

  // Recovery FSM plus registered training, redirect, flush and underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RUN;
      rcnt           <= '0;
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      upd_target     <= '0;
      redirect_valid <= 1'b0;
      redirect_addr  <= '0;
      flush          <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      upd_valid      <= pop_c;
      redirect_valid <= mispredict_c;
      flush          <= mispredict_c;
      if (pop_c) begin
        upd_pc     <= head_pc;
        upd_taken  <= x_taken;
        upd_target <= head_target;
      end
      if (mispredict_c) redirect_addr <= actual_next;
      if (underflow_c) underflow <= 1'b1;
      case (state)
        RUN: begin
          if (mispredict_c) begin
            state <= RECOVER;
            rcnt  <= RC_W'(RECOVER_CYC);
          end
        end
        RECOVER: begin
          if (rcnt <= RC_W'(1)) begin
            state <= RUN;
            rcnt  <= '0;
          end else begin
            rcnt <= rcnt - RC_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl against a queue-based model.
module tb_branch_resolve_ctrl;

  localparam int unsigned DEPTH       = 4;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned RECOVER_CYC = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              d_valid, d_is_branch, d_pred_taken;
  logic [ADDR_W-1:0] d_pc, d_target_addr, d_pred_addr;
  logic              d_ready;
  logic              x_valid, x_taken;
  logic              upd_valid, upd_taken;
  logic [ADDR_W-1:0] upd_pc, upd_target;
  logic              redirect_valid, flush, underflow;
  logic [ADDR_W-1:0] redirect_addr;
  logic [$clog2(DEPTH):0] occupancy;

  branch_resolve_ctrl #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RECOVER_CYC(RECOVER_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .d_valid(d_valid), .d_is_branch(d_is_branch), .d_pc(d_pc),
    .d_target_addr(d_target_addr), .d_pred_taken(d_pred_taken),
    .d_pred_addr(d_pred_addr), .d_ready(d_ready),
    .x_valid(x_valid), .x_taken(x_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .flush(flush),
    .occupancy(occupancy), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic        pt;
    logic [31:0] pa;
  } ent_t;

  // Reference model state
  ent_t        mq[$];
  int          rec_left;
  bit          m_uf;
  bit          e_upd_v, e_upd_t, e_red_v;
  logic [31:0] e_upd_pc, e_upd_tg, e_red_a;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    mq.delete();
    rec_left = 0; m_uf = 0;
    e_upd_v = 0; e_upd_t = 0; e_red_v = 0;
    e_upd_pc = '0; e_upd_tg = '0; e_red_a = '0;
  endtask

  function automatic bit m_ready();
    return (rec_left == 0) && (mq.size() < DEPTH);
  endfunction

  // Drive one cycle of stimulus, advance the model, sample #1 after the edge.
  task automatic step(input bit dv, input bit db, input logic [31:0] pc,
                      input logic [31:0] tg, input bit pt, input logic [31:0] pa,
                      input bit xv, input bit xt);
    bit rdy, mis;
    ent_t h;
    logic [31:0] an, pn, p4;
    @(negedge clk);
    d_valid = dv; d_is_branch = db; d_pc = pc; d_target_addr = tg;
    d_pred_taken = pt; d_pred_addr = pa; x_valid = xv; x_taken = xt;
    rdy = m_ready();
    mis = 0;
    e_upd_v = 0; e_red_v = 0;
    if (rec_left > 0) begin
      rec_left--;
    end else begin
      if (xv) begin
        if (mq.size() == 0) m_uf = 1;
        else begin
          h  = mq.pop_front();
          p4 = h.pc + 32'd4;
          an = xt ? h.target : p4;
          pn = h.pt ? h.pa : p4;
          e_upd_v = 1; e_upd_pc = h.pc; e_upd_t = xt; e_upd_tg = h.target;
          if (an != pn) begin
            mis = 1; e_red_v = 1; e_red_a = an;
            mq.delete();
            rec_left = RECOVER_CYC;
          end
        end
      end
      if (dv && db && rdy && !mis) mq.push_back('{pc, tg, pt, pa});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, '0, 0, 0);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] tg,
                      input bit pt, input logic [31:0] pa);
    step(1, 1, pc, tg, pt, pa, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    d_valid = 0; d_is_branch = 0; d_pc = '0; d_target_addr = '0;
    d_pred_taken = 0; d_pred_addr = '0; x_valid = 0; x_taken = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (occupancy !== '0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    n_checks++; if (d_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", d_ready); end
    n_checks++; if ({upd_valid, redirect_valid, flush, underflow, upd_taken} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {upd_valid, redirect_valid, flush, underflow, upd_taken}); end
    n_checks++; if ({upd_pc, upd_target, redirect_addr} !== '0) begin
      n_fail++; $display("FAIL reset_addrs: got %h %h %h expected 0", upd_pc, upd_target, redirect_addr); end
  endtask

  task automatic test_correct_predict();
    push(32'h100, 32'h200, 1, 32'h200);
    n_checks++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL cp_occ1: got %0d expected 1", occupancy); end
    step(0, 0, '0, '0, 0, '0, 1, 1);
    n_checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h100 || upd_taken !== 1'b1 || upd_target !== 32'h200) begin
      n_fail++; $display("FAIL cp_upd: got v=%b pc=%h t=%b tg=%h expected v=1 pc=100 t=1 tg=200", upd_valid, upd_pc, upd_taken, upd_target); end
    n_checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin
      n_fail++; $display("FAIL cp_noredir: got r=%b f=%b expected 0 0", redirect_valid, flush); end
    n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL cp_occ0: got %0d expected 0", occupancy); end
    idle();
    n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL cp_pulse: got %b expected 0", upd_valid); end
  endtask

  task automatic test_mispredict_recover();
    push(32'h100, 32'h180, 0, 32'h0);
    step(1, 1, 32'h400, 32'h440, 0, '0, 1, 1);
    n_checks++; if (redirect_valid !== 1'b1 || redirect_addr !== 32'h180 || flush !== 1'b1) begin
      n_fail++; $display("FAIL mp_redir: got r=%b a=%h f=%b expected 1 180 1", redirect_valid, redirect_addr, flush); end
    n_checks++; if (d_ready !== 1'b0 || occupancy !== 3'd0) begin
      n_fail++; $display("FAIL mp_ready0: got rdy=%b occ=%0d expected 0 0", d_ready, occupancy); end
    push(32'h500, 32'h540, 0, '0);
    n_checks++; if (d_ready !== 1'b0 || occupancy !== 3'd0 || flush !== 1'b0) begin
      n_fail++; $display("FAIL mp_ready1: got rdy=%b occ=%0d f=%b expected 0 0 0", d_ready, occupancy, flush); end
    push(32'h600, 32'h640, 0, '0);
    n_checks++; if (d_ready !== 1'b1 || occupancy !== 3'd0) begin
      n_fail++; $display("FAIL mp_ready2: got rdy=%b occ=%0d expected 1 0", d_ready, occupancy); end
  endtask

  task automatic test_flush_discard();
    push(32'h10, 32'h50, 1, 32'h50);
    push(32'h20, 32'h60, 0, '0);
    push(32'h30, 32'h70, 0, '0);
    n_checks++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL fd_occ3: got %0d expected 3", occupancy); end
    step(0, 0, '0, '0, 0, '0, 1, 0);
    n_checks++; if (redirect_addr !== 32'h14 || occupancy !== 3'd0 || upd_pc !== 32'h10) begin
      n_fail++; $display("FAIL fd_redir: got a=%h occ=%0d pc=%h expected 14 0 10", redirect_addr, occupancy, upd_pc); end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, '0, '0, 0, '0, 1, 0);
      n_checks++; if (upd_valid !== 1'b0 || underflow !== 1'b0) begin
        n_fail++; $display("FAIL fd_ignored: got upd=%b uf=%b expected 0 0", upd_valid, underflow); end
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) push(32'h1000 + 32'(i * 16), 32'h9000, 0, '0);
    n_checks++; if (d_ready !== 1'b0 || occupancy !== 3'd4) begin
      n_fail++; $display("FAIL full_ready: got rdy=%b occ=%0d expected 0 4", d_ready, occupancy); end
    step(1, 1, 32'h2000, 32'h2100, 0, '0, 1, 0);
    n_checks++; if (occupancy !== 3'd3 || upd_pc !== 32'h1000) begin
      n_fail++; $display("FAIL full_pushpop: got occ=%0d pc=%h expected 3 1000", occupancy, upd_pc); end
    for (int i = 1; i < 4; i++) begin
      step(0, 0, '0, '0, 0, '0, 1, 0);
      n_checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h1000 + 32'(i * 16)) begin
        n_fail++; $display("FAIL full_order: got v=%b pc=%h expected 1 %h", upd_valid, upd_pc, 32'h1000 + 32'(i * 16)); end
    end
    n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL full_drain: got %0d expected 0", occupancy); end
  endtask

  task automatic test_underflow();
    step(0, 0, '0, '0, 0, '0, 1, 1);
    n_checks++; if (underflow !== 1'b1 || upd_valid !== 1'b0) begin
      n_fail++; $display("FAIL uf_set: got uf=%b upd=%b expected 1 0", underflow, upd_valid); end
    idle(); idle();
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b expected 1", underflow); end
    do_reset();
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL uf_clear: got %b expected 0", underflow); end
  endtask

  task automatic test_wrap();
    push(32'hFFFF_FFFC, 32'h1000, 1, 32'h40);
    step(0, 0, '0, '0, 0, '0, 1, 0);
    n_checks++; if (redirect_valid !== 1'b1 || redirect_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap: got r=%b a=%h expected 1 00000000", redirect_valid, redirect_addr); end
    idle(); idle();
  endtask

  task automatic test_random();
    bit dv, db, pt, xv, xt;
    logic [31:0] pc, tg, pa;
    for (int c = 0; c < 400; c++) begin
      dv = ($urandom_range(0, 99) < 60);
      db = ($urandom_range(0, 99) < 80);
      pc = $urandom() & 32'hFFFF_FFFC;
      tg = $urandom() & 32'hFFFF_FFFC;
      pt = $urandom_range(0, 1) == 1;
      pa = ($urandom_range(0, 9) == 0) ? ($urandom() & 32'hFFFF_FFFC) : tg;
      xv = ($urandom_range(0, 99) < 40);
      xt = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) < 8 && mq.size() > 0) xt = mq[0].pt;
      step(dv, db, pc, tg, pt, pa, xv, xt);
      n_checks++; if (d_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, d_ready, m_ready()); end
      n_checks++; if (occupancy !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_occ c%0d: got %0d expected %0d", c, occupancy, mq.size()); end
      n_checks++; if (upd_valid !== e_upd_v) begin n_fail++; $display("FAIL rnd_updv c%0d: got %b expected %b", c, upd_valid, e_upd_v); end
      n_checks++; if (upd_pc !== e_upd_pc || upd_taken !== e_upd_t || upd_target !== e_upd_tg) begin
        n_fail++; $display("FAIL rnd_upd c%0d: got %h %b %h expected %h %b %h", c, upd_pc, upd_taken, upd_target, e_upd_pc, e_upd_t, e_upd_tg); end
      n_checks++; if (redirect_valid !== e_red_v || flush !== e_red_v || redirect_addr !== e_red_a) begin
        n_fail++; $display("FAIL rnd_redir c%0d: got r=%b f=%b a=%h expected %b %b %h", c, redirect_valid, flush, redirect_addr, e_red_v, e_red_v, e_red_a); end
      n_checks++; if (underflow !== m_uf) begin n_fail++; $display("FAIL rnd_uf c%0d: got %b expected %b", c, underflow, m_uf); end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_correct_predict();
    test_mispredict_recover();
    test_flush_discard();
    test_full();
    test_underflow();
    test_wrap();
    do_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
